// File: rtl/vga_scan_engine_if.sv
// vga_scan_engine_if: output bundle of the VGA scan engine.
//   master : driven by vga_scan_engine (timing, counters, tiles, sync, pulses)
//   slave  : read by the colour/overlay logic
// Optional member frame_cnt exists only when VGA_SCAN_FRAME_CNT_EN is defined.
`timescale 1ns/1ps
interface vga_scan_engine_if;
  logic       pix_en;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [5:0] tile_x;
  logic [5:0] tile_y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;
`ifdef VGA_SCAN_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
    output pix_en, x_pos, y_pos, tile_x, tile_y, video_on, hsync, vsync,
           line_start, frame_start
`ifdef VGA_SCAN_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input pix_en, x_pos, y_pos, tile_x, tile_y, video_on, hsync, vsync,
          line_start, frame_start
`ifdef VGA_SCAN_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_scan_engine.sv
// vga_scan_engine: single-clock parametrised VGA scan engine.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   vga  : vga_scan_engine_if.master -- pix_en strobe, x/y counters, tile coordinates,
//          delayed video_on/hsync/vsync, line_start/frame_start pulses
//          (and frame_cnt when VGA_SCAN_FRAME_CNT_EN is defined).
// A clock divider produces a one-clk pix_en every CLK_DIV clks; counters, tiles and the
// sync/blank delay line all advance on pix_en. hsync/vsync/video_on lag x_pos/y_pos by PIPE
// pixel ticks so a PIPE-stage colour pipeline lines up with them.
`timescale 1ns/1ps
module vga_scan_engine #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned TILE_LOG2 = 4,
  parameter int unsigned PIPE      = 2
) (
  input  logic              clk,
  input  logic              rst,
  vga_scan_engine_if.master vga
);

  localparam int unsigned HTotal  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [3:0]  DivMax  = 4'(CLK_DIV - 1);
  localparam logic [9:0]  XMax    = 10'(HTotal - 1);
  localparam logic [9:0]  YMax    = 10'(VTotal - 1);
  localparam logic [10:0] HActive = 11'(H_ACTIVE);
  localparam logic [10:0] VActive = 11'(V_ACTIVE);
  localparam logic [10:0] HsStart = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HsEnd   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VsStart = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VsEnd   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        Inactive = ~SYNC_POL;

  logic [3:0]  div_q, div_d;
  logic        pix_en_q;
  logic [9:0]  x_q, y_q, x_d, y_d;
  logic        x_wrap, y_wrap;
  logic        act_d, hs_d, vs_d;
  logic [5:0]  tile_x_q, tile_y_q, tile_x_d, tile_y_d;
  logic [PIPE:0] act_q, hs_q, vs_q;
  logic        line_start_q, frame_start_q;

  // Sync/blank terms are taken from the next counter values, so stage 0 of the delay line is
  // aligned with x_pos/y_pos and stage PIPE lags them by PIPE ticks.
  always_comb begin
    div_d    = (div_q == DivMax) ? 4'd0 : div_q + 4'd1;
    x_wrap   = (x_q == XMax);
    y_wrap   = (y_q == YMax);
    x_d      = x_wrap ? 10'd0 : x_q + 10'd1;
    y_d      = y_q;
    if (x_wrap) begin
      y_d = y_wrap ? 10'd0 : y_q + 10'd1;
    end
    act_d    = ({1'b0, x_d} < HActive) && ({1'b0, y_d} < VActive);
    hs_d     = ({1'b0, x_d} >= HsStart) && ({1'b0, x_d} < HsEnd);
    vs_d     = ({1'b0, y_d} >= VsStart) && ({1'b0, y_d} < VsEnd);
    tile_x_d = act_d ? 6'(x_d >> TILE_LOG2) : 6'd63;
    tile_y_d = act_d ? 6'(y_d >> TILE_LOG2) : 6'd63;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= '0;
      pix_en_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      tile_x_q      <= '0;
      tile_y_q      <= '0;
      act_q         <= '0;
      hs_q          <= {(PIPE + 1){Inactive}};
      vs_q          <= {(PIPE + 1){Inactive}};
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      // Captured on the last divider count, so the first strobe follows CLK_DIV clks after
      // reset release; with CLK_DIV=1 it stays high.
      pix_en_q      <= (div_q == DivMax);
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (pix_en_q) begin
        x_q           <= x_d;
        y_q           <= y_d;
        tile_x_q      <= tile_x_d;
        tile_y_q      <= tile_y_d;
        line_start_q  <= x_wrap;
        frame_start_q <= x_wrap && y_wrap;
        act_q[0]      <= act_d;
        hs_q[0]       <= hs_d ? SYNC_POL : Inactive;
        vs_q[0]       <= vs_d ? SYNC_POL : Inactive;
        for (int i = 1; i <= PIPE; i++) begin
          act_q[i] <= act_q[i-1];
          hs_q[i]  <= hs_q[i-1];
          vs_q[i]  <= vs_q[i-1];
        end
      end
    end
  end

`ifdef VGA_SCAN_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (pix_en_q && x_wrap && y_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

  assign vga.pix_en      = pix_en_q;
  assign vga.x_pos       = x_q;
  assign vga.y_pos       = y_q;
  assign vga.tile_x      = tile_x_q;
  assign vga.tile_y      = tile_y_q;
  assign vga.video_on    = act_q[PIPE];
  assign vga.hsync       = hs_q[PIPE];
  assign vga.vsync       = vs_q[PIPE];
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: doc/vga_scan_engine.md
# vga_scan_engine

Parametrised VGA scan engine for the snake game display path. It replaces the fixed 640x480 timing and the separately divided pixel clock with a single-clock design: a pixel-enable strobe, configurable horizontal and vertical timing, and sync polarity. It also produces game-grid tile coordinates and a configurable sync/blank delay line, so a multi-stage colour pipeline (snake, apple, mine and score lookup) lines up with hsync, vsync and blanking. It sits between the board clock and the colour/overlay logic that drives `color_out`.

## Interface
- CLK_DIV, 4: system clocks per pixel (range 1..16); 100 MHz / 4 = 25 MHz pixel rate.
- H_ACTIVE, H_FP, H_SYNC, H_BP, defaults 640, 16, 96, 48: horizontal timing in pixels. H_TOTAL is their sum and must be ≤1024.
- V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33: vertical timing in lines. V_TOTAL is their sum and must be ≤1024.
- SYNC_POL, 0: active level of hsync and vsync (0 = active-low).
- TILE_LOG2, 4: log2 of tile size in pixels; default gives 40x30 tiles.
- PIPE, 2: pixel ticks by which hsync, vsync and video_on lag x_pos/y_pos (range 0..4).
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- pix_en  out  1  one-clk strobe per pixel.
- x_pos  out  10  horizontal counter.
- y_pos  out  10  vertical counter.
- tile_x  out  6  x_pos>>TILE_LOG2 inside the active area, otherwise 63.
- tile_y  out  6  y_pos>>TILE_LOG2 inside the active area, otherwise 63.
- video_on  out  1  active-area flag, delayed PIPE ticks.
- hsync  out  1  horizontal sync, delayed PIPE ticks.
- vsync  out  1  vertical sync, delayed PIPE ticks.
- line_start  out  1  one-clk pulse when x_pos wraps to 0.
- frame_start  out  1  one-clk pulse when (x_pos,y_pos) wraps to (0,0).
- frame_cnt  out  16  frames completed; present only with VGA_SCAN_FRAME_CNT_EN.

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1. pix_en is registered high during the clk when div_cnt==CLK_DIV-1. With CLK_DIV=1, pix_en is permanently high after reset.
- Counters update only when pix_en is high:
  - x_pos counts 0..H_TOTAL-1, then wraps to 0.
  - On each x wrap, y_pos increments and wraps from V_TOTAL-1 to 0.
- Undelayed sync and blanking terms:
  - act = x_pos<H_ACTIVE && y_pos<V_ACTIVE.
  - hs_raw is asserted for x_pos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs_raw is asserted for y_pos in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- Delay line: act, hs_raw and vs_raw pass through a PIPE-deep shift register that advances on pix_en. Its outputs are video_on, and hsync/vsync mapped to the SYNC_POL active level. With PIPE=0 the outputs are registered copies taken in the same cycle as the counters.
- Tiles: tile_x and tile_y are registered together with the counters, so they share x_pos/y_pos timing, not the delayed timing. Bits above 6 are truncated. The value is 63 when act is 0.
- line_start and frame_start are high for exactly the pix_en clk on which the counters load the wrap value. There is no pulse for the reset state itself.
- Reset values:
  - div_cnt, x_pos, y_pos: 0.
  - pix_en, video_on, line_start, frame_start: 0.
  - tile_x, tile_y: 0.
  - hsync, vsync, all delay stages: inactive level (~SYNC_POL).
- Reset is asynchronous and may occur mid-frame. All state returns to the reset values immediately. Scanning restarts at (0,0), and the first pix_en arrives CLK_DIV clks after rst deasserts.

## Timing
- Latency from pix_en to updated x_pos/y_pos/tile: 1 clk (registered on the pix_en edge).
- hsync, vsync and video_on for pixel (x,y) appear PIPE pixel ticks after x_pos==x.
- Period of hsync = H_TOTAL·CLK_DIV clks. Period of vsync = H_TOTAL·V_TOTAL·CLK_DIV clks.
- When x wrap and y wrap happen together, line_start and frame_start both pulse in the same clk.
- All outputs are glitch-free register outputs. No derived clocks.

## Configuration
- VGA_SCAN_FRAME_CNT_EN defined: the frame_cnt port and register exist. frame_cnt increments on each frame_start, wraps 0xFFFF→0, and resets to 0.
- VGA_SCAN_FRAME_CNT_EN undefined: the port and register are omitted. All other behaviour is identical.

## Test plan
- Reset: hold rst for 5 clks. Required: x_pos=0, y_pos=0, pix_en=0, hsync=vsync=1 (SYNC_POL=0), video_on=0. First pix_en appears 4 clks after release.
- Cadence: CLK_DIV=4. Required: pix_en is high 1 clk in every 4. x_pos goes 0→799→0 over 3200 clks, and line_start pulses at each wrap.
- Sync placement (PIPE=0):
  - hsync is low for exactly 96 pixel ticks, starting at x_pos=656.
  - vsync is low for lines 490–491.
  - Frame period is 1,680,000 clks.
- Pipeline alignment: PIPE=2. Required: video_on falls exactly 2 pix_en ticks after x_pos reaches 640. tile_x reads 39 at x_pos=639 and 63 at x_pos=640.
- Mid-frame reset: assert rst at x_pos=300, y_pos=200. Required: all outputs return to reset values in the same clk. No frame_start pulse occurs, and the scan resumes from (0,0).
- Macro on: run 3 full frames, then force a counter value of 0xFFFF and run one more frame. Required: frame_cnt reads 3, then wraps 0xFFFF→0. With the macro undefined, the module elaborates without frame_cnt.
